// File: rtl/tick_gen.sv
// Programmable tick strobe generator: periodic or one-shot, with reload, enable gating and event count.
// Optional one-shot mode is built only when TICK_GEN_ONESHOT_EN is defined; otherwise the block is always periodic.
module tick_gen #(
  parameter int CNT_W      = 25,
  parameter int DEF_PERIOD = 25_000_000,
  parameter int EVT_W      = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             period_ld,
  input  logic [CNT_W-1:0] period_in,
  input  logic             oneshot,
  input  logic             start,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_val,
  output logic [EVT_W-1:0] evt_cnt
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [CNT_W-1:0] last_cnt;
  logic             at_end;

  // A zero period behaves like a period of one, so the terminal count never underflows.
  assign last_cnt = (period_q == '0) ? '0 : period_q - CNT_W'(1);
  assign at_end   = (cnt_q == last_cnt);

`ifdef TICK_GEN_ONESHOT_EN
  typedef enum logic {S_IDLE, S_ARMED} state_t;
  state_t state_q, state_d;
  logic   mode_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= oneshot;
    end
  end

  assign busy = (state_q == S_ARMED);
`else
  logic unused_oneshot_in;
  assign unused_oneshot_in = oneshot ^ start;
  assign busy = 1'b0;
`endif

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    evt_d    = evt_q;
`ifdef TICK_GEN_ONESHOT_EN
    state_d  = state_q;
`endif
    if (period_ld) begin
      period_d = period_in;
      cnt_d    = '0;
`ifdef TICK_GEN_ONESHOT_EN
      state_d  = S_IDLE;
    end else if (oneshot != mode_q) begin
      cnt_d   = '0;
      state_d = S_IDLE;
    end else if (oneshot) begin
      // Start wins over counting, so a start while armed retriggers without a tick.
      if (start) begin
        cnt_d   = '0;
        state_d = S_ARMED;
      end else if (en && state_q == S_ARMED) begin
        if (at_end) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
    end else if (en) begin
      if (at_end) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (tick_d) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      period_q <= CNT_W'(DEF_PERIOD);
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      evt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      evt_q    <= evt_d;
    end
  end

  assign tick    = tick_q;
  assign cnt_val = cnt_q;
  assign evt_cnt = evt_q;

endmodule
